// File: rtl/mem_bus_bridge_if.sv
// rtl/mem_bus_bridge_if.sv - CPU request/ack bus and memory command bus bundle
interface mem_bus_bridge_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 12,
   parameter int CPU_ADDR_WIDTH = 16
);
   logic                      cpu_req;
   logic                      cpu_we;
   logic [CPU_ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0]     cpu_wdata;
   logic [DATA_WIDTH-1:0]     cpu_rdata;
   logic                      cpu_ack;
   logic                      cpu_err;
   logic                      mem_rd_enable;
   logic                      mem_wr_enable;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic [DATA_WIDTH-1:0]     mem_wr_data;
   logic                      mem_busy;
   logic [DATA_WIDTH-1:0]     mem_rd_data;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_busy, mem_rd_data,
      output cpu_rdata, cpu_ack, cpu_err, mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_busy, mem_rd_data,
      input  cpu_rdata, cpu_ack, cpu_err, mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/mem_bus_bridge.sv
// rtl/mem_bus_bridge.sv - CPU request/ack bus to single-cycle memory command bridge with timeout
module mem_bus_bridge #(
   parameter int                        DATA_WIDTH     = 8,
   parameter int                        ADDR_WIDTH     = 12,
   parameter int                        CPU_ADDR_WIDTH = 16,
   parameter logic [CPU_ADDR_WIDTH-1:0] BASE_ADDR      = 16'h0000,
   parameter int                        TIMEOUT        = 15,
   parameter logic [DATA_WIDTH-1:0]     OPEN_BUS       = 8'hFF
) (
   input logic              clk_i,
   input logic              reset_ni,
   mem_bus_bridge_if.slave  bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP} state_e;

   state_e                    state_q;
   logic                      we_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [DATA_WIDTH-1:0]     cpu_rdata_q;
   logic                      cpu_ack_q;
   logic                      cpu_err_q;
   logic                      mem_rd_en_q;
   logic                      mem_wr_en_q;
   logic [ADDR_WIDTH-1:0]     mem_addr_q;
   logic [DATA_WIDTH-1:0]     mem_wr_data_q;

   logic [CPU_ADDR_WIDTH-1:0] offset_d;
   logic                      hit_d;
   logic [CNT_W-1:0]          cnt_d;
   logic                      timeout_d;

   // Offset-based decode avoids overflow when the window ends at the top of the CPU space.
   always_comb begin
      offset_d  = bus.cpu_addr - BASE_ADDR;
      hit_d     = (bus.cpu_addr >= BASE_ADDR) && (offset_d[CPU_ADDR_WIDTH-1:ADDR_WIDTH] == '0);
      cnt_d     = cnt_q + 1'b1;
      timeout_d = (cnt_d >= CNT_W'(TIMEOUT));
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         cnt_q         <= '0;
         cpu_rdata_q   <= '0;
         cpu_ack_q     <= 1'b0;
         cpu_err_q     <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
      end else begin
         mem_rd_en_q <= 1'b0;
         mem_wr_en_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.cpu_req && !bus.mem_busy) begin
                  we_q <= bus.cpu_we;
                  if (hit_d) begin
                     mem_addr_q    <= offset_d[ADDR_WIDTH-1:0];
                     mem_wr_data_q <= bus.cpu_wdata;
                     mem_rd_en_q   <= !bus.cpu_we;
                     mem_wr_en_q   <= bus.cpu_we;
                     state_q       <= ISSUE;
                  end else begin
                     if (!bus.cpu_we) cpu_rdata_q <= OPEN_BUS;
                     cpu_ack_q <= 1'b1;
                     state_q   <= RESP;
                  end
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT_HI;
            end
            WAIT_HI: begin
               cnt_q <= cnt_d;
               if (timeout_d) begin
                  if (!we_q) cpu_rdata_q <= OPEN_BUS;
                  cpu_ack_q <= 1'b1;
                  cpu_err_q <= 1'b1;
                  state_q   <= RESP;
               end else if (bus.mem_busy) begin
                  state_q <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               cnt_q <= cnt_d;
               // A completion landing on the last allowed cycle wins over the abort.
               if (!bus.mem_busy) begin
                  if (!we_q) cpu_rdata_q <= bus.mem_rd_data;
                  cpu_ack_q <= 1'b1;
                  state_q   <= RESP;
               end else if (timeout_d) begin
                  if (!we_q) cpu_rdata_q <= OPEN_BUS;
                  cpu_ack_q <= 1'b1;
                  cpu_err_q <= 1'b1;
                  state_q   <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cpu_rdata     = cpu_rdata_q;
   assign bus.cpu_ack       = cpu_ack_q;
   assign bus.cpu_err       = cpu_err_q;
   assign bus.mem_rd_enable = mem_rd_en_q;
   assign bus.mem_wr_enable = mem_wr_en_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wr_data   = mem_wr_data_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb/tb_mem_bus_bridge.sv - directed self-checking bench for mem_bus_bridge
module tb_mem_bus_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_bus_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .CPU_ADDR_WIDTH(16)) bus ();
   mem_bus_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .CPU_ADDR_WIDTH(16)) bus2 ();

   mem_bus_bridge #(
      .DATA_WIDTH(8), .ADDR_WIDTH(12), .CPU_ADDR_WIDTH(16),
      .BASE_ADDR(16'h0000), .TIMEOUT(15), .OPEN_BUS(8'hFF)
   ) dut (.clk_i(clk), .reset_ni(rst_n), .bus(bus));

   mem_bus_bridge #(
      .DATA_WIDTH(8), .ADDR_WIDTH(12), .CPU_ADDR_WIDTH(16),
      .BASE_ADDR(16'hF000), .TIMEOUT(15), .OPEN_BUS(8'hFF)
   ) dut2 (.clk_i(clk), .reset_ni(rst_n), .bus(bus2));

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   // Memory model: busy high for two cycles after each command, read data valid when busy falls.
   logic [7:0]  mem [0:4095];
   logic        m_busy = 1'b0;
   int          m_left = 0;
   logic [11:0] m_addr = '0;
   logic [7:0]  m_rdata = '0;
   logic        busy_force = 1'b0;
   logic        mem_dead = 1'b0;

   int          rd_cnt = 0, wr_cnt = 0, rd2_cnt = 0, ack_cnt = 0;
   logic [11:0] last_addr = '0, last_addr2 = '0;
   logic [7:0]  last_wdata = '0;
   logic        both_seen = 1'b0, err_wo_ack = 1'b0;

   assign bus.mem_busy    = m_busy | busy_force;
   assign bus.mem_rd_data = m_rdata;

   always @(posedge clk) begin
      if ((bus.mem_rd_enable || bus.mem_wr_enable) && !mem_dead) begin
         m_busy <= 1'b1;
         m_left <= 1;
         m_addr <= bus.mem_addr;
         if (bus.mem_wr_enable) mem[bus.mem_addr] <= bus.mem_wr_data;
      end else if (m_busy) begin
         if (m_left == 0) begin
            m_busy  <= 1'b0;
            m_rdata <= mem[m_addr];
         end else begin
            m_left <= m_left - 1;
         end
      end
      if (bus.mem_rd_enable) rd_cnt <= rd_cnt + 1;
      if (bus.mem_wr_enable) wr_cnt <= wr_cnt + 1;
      if (bus.mem_rd_enable || bus.mem_wr_enable) begin
         last_addr  <= bus.mem_addr;
         last_wdata <= bus.mem_wr_data;
      end
      if (bus2.mem_rd_enable) begin
         rd2_cnt    <= rd2_cnt + 1;
         last_addr2 <= bus2.mem_addr;
      end
      if (bus.cpu_ack) ack_cnt <= ack_cnt + 1;
      if (bus.mem_rd_enable && bus.mem_wr_enable) both_seen <= 1'b1;
      if ((bus.cpu_err && !bus.cpu_ack) || (bus2.cpu_err && !bus2.cpu_ack)) err_wo_ack <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input bit d2, input logic we, input logic [15:0] addr, input logic [7:0] wd);
      if (d2) begin
         bus2.cpu_req = 1'b1; bus2.cpu_we = we; bus2.cpu_addr = addr; bus2.cpu_wdata = wd;
      end else begin
         bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
      end
   endtask

   task automatic wait_ack(input bit d2, output int lat, output logic err, output logic [7:0] rd);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!(d2 ? bus2.cpu_ack : bus.cpu_ack) && lat < 40);
      err = d2 ? bus2.cpu_err : bus.cpu_err;
      rd  = d2 ? bus2.cpu_rdata : bus.cpu_rdata;
   endtask

   task automatic access(input bit d2, input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         output int lat, output logic err, output logic [7:0] rd);
      start(d2, we, addr, wd);
      wait_ack(d2, lat, err, rd);
      if (d2) bus2.cpu_req = 1'b0; else bus.cpu_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int         lat, r0, w0, a0;
      logic       err;
      logic [7:0] rd;

      bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
      bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
      bus2.mem_busy = 1'b0; bus2.mem_rd_data = 8'h00;

      repeat (2) @(negedge clk);
      check("reset_outputs", {bus.cpu_rdata, bus.cpu_ack, bus.cpu_err, bus.mem_rd_enable,
                              bus.mem_wr_enable, bus.mem_addr, bus.mem_wr_data}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      r0 = rd_cnt; w0 = wr_cnt;
      access(0, 1'b1, 16'h0123, 8'hA5, lat, err, rd);
      check("wr_latency", lat, 5);
      check("wr_err", err, 0);
      check("wr_pulses", wr_cnt - w0, 1);
      check("wr_no_rd", rd_cnt - r0, 0);
      check("wr_addr", last_addr, 12'h123);
      check("wr_data", last_wdata, 8'hA5);

      r0 = rd_cnt;
      access(0, 1'b0, 16'h0123, 8'h00, lat, err, rd);
      check("rd_latency", lat, 5);
      check("rd_data", rd, 8'hA5);
      check("rd_pulses", rd_cnt - r0, 1);

      r0 = rd_cnt; w0 = wr_cnt;
      access(0, 1'b0, 16'h1000, 8'h00, lat, err, rd);
      check("miss_rd_latency", lat, 1);
      check("miss_rd_data", rd, 8'hFF);
      check("miss_rd_no_cmd", (rd_cnt - r0) + (wr_cnt - w0), 0);

      r0 = rd_cnt; w0 = wr_cnt;
      access(0, 1'b1, 16'h2000, 8'h11, lat, err, rd);
      check("miss_wr_latency", lat, 1);
      check("miss_wr_err", err, 0);
      check("miss_wr_no_cmd", (rd_cnt - r0) + (wr_cnt - w0), 0);
      check("miss_wr_rdata_held", rd, 8'hFF);

      r0 = rd2_cnt;
      access(1, 1'b0, 16'hFFFF, 8'h00, lat, err, rd);
      check("top_hit_pulse", rd2_cnt - r0, 1);
      check("top_hit_addr", last_addr2, 12'hFFF);
      check("top_hit_timeout_lat", lat, 17);
      check("top_hit_timeout_err", err, 1);
      r0 = rd2_cnt;
      access(1, 1'b0, 16'hEFFF, 8'h00, lat, err, rd);
      check("below_base_latency", lat, 1);
      check("below_base_data", rd, 8'hFF);
      check("below_base_no_cmd", rd2_cnt - r0, 0);

      mem_dead = 1'b1;
      access(0, 1'b0, 16'h0010, 8'h00, lat, err, rd);
      check("timeout_latency", lat, 17);
      check("timeout_err", err, 1);
      check("timeout_data", rd, 8'hFF);
      mem_dead = 1'b0;
      access(0, 1'b0, 16'h0123, 8'h00, lat, err, rd);
      check("after_timeout_latency", lat, 5);
      check("after_timeout_err", err, 0);
      check("after_timeout_data", rd, 8'hA5);

      r0 = rd_cnt;
      start(0, 1'b0, 16'h0001, 8'h00);
      wait_ack(0, lat, err, rd);
      check("b2b_first_latency", lat, 5);
      check("b2b_first_addr", last_addr, 12'h001);
      bus.cpu_addr = 16'h0002;
      wait_ack(0, lat, err, rd);
      check("b2b_second_latency", lat, 6);
      check("b2b_second_addr", last_addr, 12'h002);
      check("b2b_pulses", rd_cnt - r0, 2);
      bus.cpu_req = 1'b0;
      @(negedge clk);

      start(0, 1'b0, 16'h0123, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", {bus.cpu_rdata, bus.cpu_ack, bus.cpu_err, bus.mem_rd_enable,
                                 bus.mem_wr_enable, bus.mem_addr, bus.mem_wr_data}, 32'h0);
      bus.cpu_req = 1'b0;
      a0 = ack_cnt;
      repeat (3) @(negedge clk);
      check("midreset_no_ack", ack_cnt - a0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      busy_force = 1'b1;
      r0 = rd_cnt;
      start(0, 1'b0, 16'h0003, 8'h00);
      repeat (3) @(negedge clk);
      check("busy_holds_idle", rd_cnt - r0, 0);
      busy_force = 1'b0;
      wait_ack(0, lat, err, rd);
      bus.cpu_req = 1'b0;
      check("post_busy_latency", lat, 5);
      check("post_busy_err", err, 0);
      check("post_busy_addr", last_addr, 12'h003);
      check("post_busy_pulses", rd_cnt - r0, 1);
      @(negedge clk);

      check("never_both_enables", both_seen, 0);
      check("no_err_without_ack", err_wo_ack, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
